// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming encoder: SEC, or SEC-DED with an appended overall parity bit.
// One-cycle registered encode feeding a 2-entry skid buffer (output register plus
// one skid register), so the input side never sees out_ready combinationally.
// An optional test hook flips one codeword bit of an accepted word after parity
// generation.
module hamming_stream_encoder #(
   parameter  int DATA_W = 16,
   parameter  int SECDED = 0,
   // Smallest P with 2^P >= DATA_W + P + 1, resolved over the legal DATA_W range.
   localparam int P      = (DATA_W + 3 <= 4)  ? 2 :
                           (DATA_W + 4 <= 8)  ? 3 :
                           (DATA_W + 5 <= 16) ? 4 :
                           (DATA_W + 6 <= 32) ? 5 :
                           (DATA_W + 7 <= 64) ? 6 : 7,
   localparam int CODE_W = DATA_W + P + SECDED,
   localparam int EW     = $clog2(CODE_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic              err_inject,
   input  logic [EW-1:0]     err_pos,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] data_out,
   output logic [15:0]       word_cnt
);

   // Width of the plain Hamming part (data plus check bits, no overall parity).
   localparam int HAM_W = DATA_W + P;

   logic [CODE_W-1:0] enc_word;
   logic [CODE_W-1:0] flip_mask;
   logic [CODE_W-1:0] out_data;
   logic [CODE_W-1:0] skid_data;
   logic              out_vld;
   logic              skid_vld;
   logic              skid_nxt;
   logic              rdy;
   logic              in_fire;
   logic              out_fire;
   logic              out_free;
   logic [15:0]       cnt;

   // Places payload bits into the non-power-of-two positions (1-indexed), then
   // computes each check bit p(k+1) at position 2^k as the XOR of all
   // data-bearing positions whose position number has bit k set.
   function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] cw;
      logic              par;
      int                j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos <= HAM_W; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos-1] = d[j];
            j++;
         end
      end
      for (int k = 0; k < P; k++) begin
         par = 1'b0;
         for (int pos = 1; pos <= HAM_W; pos++) begin
            if (((pos & (pos - 1)) != 0) && (((pos >> k) & 1) != 0)) begin
               par ^= cw[pos-1];
            end
         end
         cw[(1 << k) - 1] = par;
      end
      // Overall parity covers the finished SEC word, before any injected error.
      if (SECDED != 0) begin
         cw[CODE_W-1] = ^cw[HAM_W-1:0];
      end
      return cw;
   endfunction

   // A shift past the top of the codeword yields an all-zero mask, so err_pos
   // values at or above CODE_W naturally inject nothing.
   assign flip_mask = err_inject ? (CODE_W'(1) << err_pos) : '0;
   assign enc_word  = encode(data_in) ^ flip_mask;

   assign in_fire  = in_valid & rdy;
   assign out_fire = out_vld & out_ready;
   assign out_free = ~out_vld | out_ready;

   // Skid occupancy after this edge: drains whenever the output register can
   // take a word, fills when an input arrives against a stalled output.
   always_comb begin
      skid_nxt = skid_vld;
      if (out_free) begin
         skid_nxt = 1'b0;
      end else if (in_fire) begin
         skid_nxt = 1'b1;
      end
   end

   // Output register: refilled from the skid entry first to keep word order,
   // otherwise straight from the encoder (also on a simultaneous in/out transfer).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (out_free) begin
         if (skid_vld) begin
            out_vld  <= 1'b1;
            out_data <= skid_data;
         end else if (in_fire) begin
            out_vld  <= 1'b1;
            out_data <= enc_word;
         end else begin
            out_vld  <= 1'b0;
         end
      end
   end

   // Skid register: captures the encoded word when the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_vld  <= 1'b0;
         skid_data <= '0;
      end else begin
         skid_vld <= skid_nxt;
         if (!out_free && in_fire) begin
            skid_data <= enc_word;
         end
      end
   end

   // Registered ready: low in reset, then tracks skid-empty one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy <= 1'b0;
      end else begin
         rdy <= ~skid_nxt;
      end
   end

   // Count of output transfers, free-running with natural 16-bit wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (out_fire) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign in_ready  = rdy;
   assign out_valid = out_vld;
   assign data_out  = out_data;
   assign word_cnt  = cnt;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Self-checking bench for hamming_stream_encoder: a SEC instance and a SEC-DED
// instance share stimulus; accepted inputs push expected codewords to a
// scoreboard that is popped on each output transfer.
module tb_hamming_stream_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        err_inject = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] data_in = '0;
   logic [4:0]  err_pos = '0;

   logic        in_ready, out_valid, sd_in_ready, sd_out_valid;
   logic [20:0] data_out;
   logic [21:0] sd_data_out;
   logic [15:0] word_cnt, sd_word_cnt;

   typedef struct {
      logic [20:0] e0;
      logic [21:0] e1;
   } exp_t;

   exp_t        sb[$];
   exp_t        ent;
   int          n_vec = 0;
   int          n_miss = 0;
   int          n_push = 0;
   int          total_out = 0;
   int          rnd_start = 0;
   int          rnd_cyc = 0;
   logic [15:0] exp_cnt = '0;
   logic        hold_pend = 1'b0;
   logic [20:0] held = '0;

   hamming_stream_encoder #(.DATA_W(16), .SECDED(0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .err_inject(err_inject), .err_pos(err_pos),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .word_cnt(word_cnt)
   );

   hamming_stream_encoder #(.DATA_W(16), .SECDED(1)) dut_sd (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(sd_in_ready), .data_in(data_in),
      .err_inject(err_inject), .err_pos(err_pos),
      .out_valid(sd_out_valid), .out_ready(out_ready), .data_out(sd_data_out),
      .word_cnt(sd_word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: the check-bit vector equals the XOR of the position numbers of
   // all set data bits; check bit k sits at position 2^k.
   function automatic logic [21:0] model(input logic [15:0] d, input int sd,
                                         input logic inj, input logic [4:0] ep);
      logic [21:0] cw;
      logic [4:0]  syn;
      int          pos;
      int          width;
      cw  = '0;
      syn = '0;
      pos = 1;
      for (int i = 0; i < 16; i++) begin
         while ((pos & (pos - 1)) == 0) pos++;
         cw[pos-1] = d[i];
         if (d[i]) syn ^= 5'(pos);
         pos++;
      end
      for (int k = 0; k < 5; k++) cw[(1 << k) - 1] = syn[k];
      if (sd != 0) cw[21] = ^cw[20:0];
      width = (sd != 0) ? 22 : 21;
      if (inj && int'(ep) < width) cw[ep] = ~cw[ep];
      return cw;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge what the next rising edge will transfer.
   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend && out_valid) chk("hold", 64'(data_out), 64'(held));
         hold_pend = out_valid && !out_ready;
         held      = data_out;
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               ent = sb.pop_front();
               chk("dout", 64'(data_out), 64'(ent.e0));
               chk("dout_sd", 64'(sd_data_out), 64'(ent.e1));
               chk("sd_ovalid", 64'(sd_out_valid), 64'(1));
               chk("wcnt", 64'(word_cnt), 64'(exp_cnt));
               chk("wcnt_sd", 64'(sd_word_cnt), 64'(exp_cnt));
            end
            exp_cnt   = exp_cnt + 16'd1;
            total_out = total_out + 1;
         end
         if (in_valid && in_ready) begin
            sb.push_back('{e0: 21'(model(data_in, 0, err_inject, err_pos)),
                           e1: model(data_in, 1, err_inject, err_pos)});
            n_push++;
            chk("sd_rdy", 64'(sd_in_ready), 64'(1));
         end
      end
   end

   task automatic single(input logic [15:0] d, input logic inj, input logic [4:0] ep,
                         input logic [20:0] want, input logic [21:0] want_sd,
                         input string tag);
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      data_in    = d;
      err_inject = inj;
      err_pos    = ep;
      tick();
      in_valid   = 1'b0;
      err_inject = 1'b0;
      chk({tag, "_v"}, 64'(out_valid), 64'(1));
      chk(tag, 64'(data_out), 64'(want));
      chk({tag, "_sd"}, 64'(sd_data_out), 64'(want_sd));
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      sb.delete();
      exp_cnt   = '0;
      total_out = 0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_ovalid", 64'(out_valid), 64'(0));
      chk("rst_irdy", 64'(in_ready), 64'(0));
      chk("rst_dout", 64'(data_out), 64'(0));
      chk("rst_wcnt", 64'(word_cnt), 64'(0));
      tick();
      tick();
      rst = 1'b0;
      #1 chk("irdy_pre_edge", 64'(in_ready), 64'(0));
      tick();
      chk("irdy_post_edge", 64'(in_ready), 64'(1));

      single(16'h0001, 1'b0, 5'd0,  21'h000007, 22'h200007, "enc_0001");
      single(16'hFFFF, 1'b0, 5'd0,  21'h1FFFFE, 22'h1FFFFE, "enc_ffff");
      single(16'h0001, 1'b1, 5'd2,  21'h000003, 22'h200003, "inj_pos2");
      single(16'h0001, 1'b1, 5'd21, 21'h000007, 22'h000007, "inj_pos21");
      single(16'h0001, 1'b1, 5'd31, 21'h000007, 22'h200007, "inj_pos31");
      single(16'h0001, 1'b1, 5'd0,  21'h000006, 22'h200006, "inj_pos0");

      // err_inject without an input transfer must leave later words intact
      err_inject = 1'b1;
      err_pos    = 5'd4;
      tick();
      single(16'h8001, 1'b0, 5'd4, 21'(model(16'h8001, 0, 1'b0, 5'd0)),
             model(16'h8001, 1, 1'b0, 5'd0), "inj_idle");

      // Back-pressure: three words against a stalled output
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 16'h1234;
      tick();
      data_in = 16'hABCD;
      tick();
      chk("bp_irdy_low", 64'(in_ready), 64'(0));
      chk("bp_ovalid", 64'(out_valid), 64'(1));
      chk("bp_head", 64'(data_out), 64'(21'(model(16'h1234, 0, 1'b0, 5'd0))));
      data_in = 16'h0F0F;
      tick();
      tick();
      chk("bp_stall_irdy", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      tick();
      chk("bp_irdy_back", 64'(in_ready), 64'(1));
      chk("bp_second", 64'(data_out), 64'(21'(model(16'hABCD, 0, 1'b0, 5'd0))));
      tick();
      in_valid = 1'b0;
      chk("bp_third", 64'(data_out), 64'(21'(model(16'h0F0F, 0, 1'b0, 5'd0))));
      tick();
      chk("bp_wcnt3", 64'(word_cnt), 64'(3));
      chk("bp_empty", 64'(out_valid), 64'(0));

      // Reset with both buffers full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 16'h5555;
      tick();
      data_in = 16'h3C3C;
      tick();
      in_valid = 1'b0;
      chk("full_irdy", 64'(in_ready), 64'(0));
      rst = 1'b1;
      #1;
      chk("mid_ovalid", 64'(out_valid), 64'(0));
      chk("mid_irdy", 64'(in_ready), 64'(0));
      chk("mid_dout", 64'(data_out), 64'(0));
      chk("mid_wcnt", 64'(word_cnt), 64'(0));
      sb.delete();
      exp_cnt   = '0;
      total_out = 0;
      tick();
      rst = 1'b0;
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = 16'h00A5;
      tick();
      in_valid = 1'b0;
      chk("post_rst_ovalid", 64'(out_valid), 64'(1));
      chk("post_rst_first", 64'(data_out), 64'(21'(model(16'h00A5, 0, 1'b0, 5'd0))));
      tick();

      // Random stream with random back-pressure
      rnd_start = n_push;
      rnd_cyc   = 0;
      while ((n_push - rnd_start) < 70000 && rnd_cyc < 90000) begin
         in_valid   = ($urandom_range(0, 31) != 0);
         out_ready  = ($urandom_range(0, 31) != 0);
         data_in    = 16'($urandom);
         err_inject = ($urandom_range(0, 15) == 0);
         err_pos    = 5'($urandom);
         tick();
         rnd_cyc++;
      end
      chk("rnd_words", 64'((n_push - rnd_start) >= 70000), 64'(1));
      in_valid   = 1'b0;
      err_inject = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         tick();
      end
      chk("drain", 64'(sb.size()), 64'(0));
      chk("drain_ovalid", 64'(out_valid), 64'(0));
      chk("wrap_seen", 64'(total_out > 65535), 64'(1));
      chk("final_wcnt", 64'(word_cnt), 64'(total_out % 65536));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

endmodule
